// File: rtl/cnt_vld_receiver_pkg.sv
// Shared definitions for the digit-counter stream receiver: FSM state
// encoding, 7-segment patterns for hex digits, and the BCD wrap-counter step.
package cnt_vld_receiver_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, for 0..F.
    localparam logic [6:0] SEG_PAT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Two-digit BCD increment {tens, ones}; 99 rolls over to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/cnt_vld_receiver_seg7_decode.sv
// Hex digit to 7-segment pattern decoder. Only present when SEG7_EN is
// defined; the default build has no display path.
`ifdef SEG7_EN
module seg7_decode
    import cnt_vld_receiver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_PAT[hex];

endmodule
`endif

// File: rtl/cnt_vld_receiver.sv
// Receive side of the digit counter stream. Locks onto the 0..MAX_VAL
// sequence, flags out-of-sequence samples, counts errors (saturating) and
// completed wraps (two-digit BCD). Optional macro SEG7_EN adds a registered
// 7-segment pattern of the last accepted digit; otherwise seg is 7'h00.
//
// Stream protocol: vld_in qualifies cnt_in at each rising clk edge. There is
// no ready; the receiver consumes every valid sample, back-to-back included.
module cnt_vld_receiver
    import cnt_vld_receiver_pkg::*;
#(
    parameter int MAX_VAL = 9,
    parameter int GAP_MAX = 8,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    input  logic             vld_in,
    output logic             locked,
    output logic [3:0]       digit,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       wraps,
    output logic [6:0]       seg,
    output logic [1:0]       state_dbg
);

    localparam logic [3:0]       MAX4     = 4'(MAX_VAL);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_MAX - 1);
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] expected;
    logic [7:0] idle_cnt;

    logic sync0;
    logic accept;
    logic mismatch;

    // A valid 0 outside TRACK (re)synchronises; inside TRACK a valid sample
    // either matches the expected value or is a sequence error.
    assign sync0    = vld_in && (cnt_in == 4'd0) && (state != TRACK);
    assign accept   = vld_in && (state == TRACK) && (cnt_in == expected);
    assign mismatch = vld_in && (state == TRACK) && (cnt_in != expected);

    assign state_dbg = state;

    // Sequence tracker: lock, accept/compare, idle timeout, error and wrap tallies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            locked   <= 1'b0;
            digit    <= 4'd0;
            expected <= 4'd0;
            idle_cnt <= 8'd0;
            seq_err  <= 1'b0;
            err_cnt  <= '0;
            wraps    <= 8'h00;
        end else begin
            seq_err <= 1'b0;
            case (state)
                HUNT, ERR: begin
                    // First 0 after losing lock is a start point, not a wrap.
                    if (sync0) begin
                        state    <= TRACK;
                        locked   <= 1'b1;
                        digit    <= 4'd0;
                        expected <= 4'd1;
                        idle_cnt <= 8'd0;
                    end
                end
                TRACK: begin
                    if (accept) begin
                        digit    <= cnt_in;
                        expected <= (cnt_in == MAX4) ? 4'd0 : cnt_in + 4'd1;
                        idle_cnt <= 8'd0;
                        if (cnt_in == 4'd0) begin
                            wraps <= bcd_inc(wraps);
                        end
                    end else if (mismatch) begin
                        seq_err  <= 1'b1;
                        state    <= ERR;
                        locked   <= 1'b0;
                        idle_cnt <= 8'd0;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_ONE;
                        end
                    end else if (idle_cnt == GAP_LAST) begin
                        // GAP_MAX-th consecutive idle cycle: give up the lock.
                        state    <= HUNT;
                        locked   <= 1'b0;
                        idle_cnt <= 8'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG7_EN
    logic [6:0] seg_dec;

    // Decode the incoming sample so the pattern is loaded in the same edge
    // as digit and stays aligned with it.
    seg7_decode u_seg7_decode (
        .hex (cnt_in),
        .seg (seg_dec)
    );

    // Display register follows every digit load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_PAT[0];
        end else if (sync0 || accept) begin
            seg <= seg_dec;
        end
    end
`else
    assign seg = 7'h00;
`endif

endmodule
